// File: rtl/lmmi_config_arbiter_if.sv
// lmmi_config_arbiter_if: fabric requester bus and LMMI hard-IP port of the config arbiter.
// slave = arbiter view, master = fabric/IP environment view.
interface lmmi_config_arbiter_if #(
    parameter int N_REQ    = 2,
    parameter int OFFSET_W = 7,
    parameter int DATA_W   = 8
);
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ-1:0]          req_ready;
    logic [N_REQ-1:0]          req_wr;
    logic [N_REQ*OFFSET_W-1:0] req_offset;
    logic [N_REQ*DATA_W-1:0]   req_wdata;
    logic [N_REQ-1:0]          rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic                      lmmi_request;
    logic                      lmmi_wr_rdn;
    logic [OFFSET_W-1:0]       lmmi_offset;
    logic [DATA_W-1:0]         lmmi_wdata;
    logic                      lmmi_ready;
    logic [DATA_W-1:0]         lmmi_rdata;
    logic                      lmmi_rdata_valid;
    logic                      init_done;
    logic                      init_err;

    modport slave (
        input  req_valid, req_wr, req_offset, req_wdata, lmmi_ready, lmmi_rdata, lmmi_rdata_valid,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, lmmi_request, lmmi_wr_rdn, lmmi_offset,
               lmmi_wdata, init_done, init_err
    );

    modport master (
        output req_valid, req_wr, req_offset, req_wdata, lmmi_ready, lmmi_rdata, lmmi_rdata_valid,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, lmmi_request, lmmi_wr_rdn, lmmi_offset,
               lmmi_wdata, init_done, init_err
    );
endinterface

// File: rtl/lmmi_config_arbiter.sv
// lmmi_config_arbiter: replays an init write table into an LMMI hard IP, then round-robin
// shares its config port between fabric requesters, one transaction at a time with timeout.
module lmmi_config_arbiter #(
    parameter int N_REQ    = 2,
    parameter int OFFSET_W = 7,
    parameter int DATA_W   = 8,
    parameter int INIT_LEN = 2,
    parameter logic [16*(OFFSET_W+DATA_W)-1:0] INIT_TABLE = '0,
    parameter int TIMEOUT  = 255
) (
    input logic                  clk,
    input logic                  resetn,
    lmmi_config_arbiter_if.slave bus
);
    localparam int EW = OFFSET_W + DATA_W;
    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;
    localparam logic [2:0] S_RST   = (INIT_LEN == 0) ? S_IDLE : S_INIT;
    localparam logic [3:0] LAST    = 4'(INIT_LEN - 1);
    localparam logic [7:0] TO      = 8'(TIMEOUT);
    localparam logic [7:0] TO_M1   = 8'(TIMEOUT - 1);
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [2:0]          r_state;
    logic                r_req;
    logic                r_wr;
    logic [OFFSET_W-1:0] r_off;
    logic [DATA_W-1:0]   r_wd;
    logic [3:0]          r_k;
    logic [7:0]          r_cnt;
    logic [1:0]          r_rr;
    logic [1:0]          r_g;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic                r_done;
    logic                r_ierr;

    logic [N_REQ-1:0]    w_rot;
    logic                w_any;
    logic [1:0]          w_gnt;
    logic [1:0]          w_rr_nx;
    logic [3:0]          w_nk;
    logic [EW-1:0]       w_ent;
    logic [OFFSET_W-1:0] w_off;
    logic [DATA_W-1:0]   w_wd;
    logic                w_wr;

    // Rotate so bit 0 is rr_ptr; scanning downwards leaves the first hit at/after rr_ptr.
    always_comb begin
        w_rot = N_REQ'({bus.req_valid, bus.req_valid} >> r_rr);
        w_any = 1'b0;
        w_gnt = r_rr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_any = 1'b1;
                w_gnt = 2'((int'(r_rr) + i) % N_REQ);
            end
        end
    end

    assign w_rr_nx = (w_gnt == 2'(N_REQ - 1)) ? 2'd0 : w_gnt + 2'd1;
    assign w_off   = OFFSET_W'(bus.req_offset >> (int'(w_gnt) * OFFSET_W));
    assign w_wd    = DATA_W'(bus.req_wdata >> (int'(w_gnt) * DATA_W));
    assign w_wr    = 1'(bus.req_wr >> w_gnt);
    // The first init entry is loaded with the request still low, later ones on advance.
    assign w_nk    = r_req ? r_k + 4'd1 : r_k;
    assign w_ent   = EW'(INIT_TABLE >> (int'(w_nk) * EW));

    assign bus.req_ready    = (r_state == S_IDLE && w_any) ? ONE << w_gnt : '0;
    assign bus.rsp_valid    = (r_state == S_RESP) ? ONE << r_g : '0;
    assign bus.rsp_rdata    = r_rdata;
    assign bus.rsp_err      = r_err;
    assign bus.lmmi_request = r_req;
    assign bus.lmmi_wr_rdn  = r_wr;
    assign bus.lmmi_offset  = r_off;
    assign bus.lmmi_wdata   = r_wd;
    assign bus.init_done    = r_done;
    assign bus.init_err     = r_ierr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_RST;
            r_req   <= 1'b0;
            r_wr    <= 1'b0;
            r_off   <= '0;
            r_wd    <= '0;
            r_k     <= '0;
            r_cnt   <= '0;
            r_rr    <= '0;
            r_g     <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_ierr  <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (!r_req || bus.lmmi_ready || r_cnt == TO_M1) begin
                        if (r_req && !bus.lmmi_ready) r_ierr <= 1'b1;
                        if (r_req && r_k == LAST) begin
                            r_req   <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_req          <= 1'b1;
                            r_wr           <= 1'b1;
                            {r_off, r_wd}  <= w_ent;
                            r_k            <= w_nk;
                            r_cnt          <= '0;
                        end
                    end else r_cnt <= r_cnt + 8'd1;
                end
                S_IDLE: begin
                    if (w_any) begin
                        r_state <= S_ISSUE;
                        r_req   <= 1'b1;
                        r_wr    <= w_wr;
                        r_off   <= w_off;
                        r_wd    <= w_wd;
                        r_g     <= w_gnt;
                        r_rr    <= w_rr_nx;
                        r_cnt   <= '0;
                        r_rdata <= '0;
                        r_err   <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    // Request is dropped one cycle before the abort so a late ready cannot land.
                    if (r_cnt == TO) begin
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else if (bus.lmmi_ready) begin
                        r_req <= 1'b0;
                        if (r_wr || bus.lmmi_rdata_valid) begin
                            if (!r_wr) r_rdata <= bus.lmmi_rdata;
                            r_state <= S_RESP;
                        end else r_state <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == TO_M1) r_req <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (bus.lmmi_rdata_valid) begin
                        r_rdata <= bus.lmmi_rdata;
                        r_state <= S_RESP;
                    end else if (r_cnt >= TO) begin
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else r_cnt <= r_cnt + 8'd1;
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
